uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DIV_W, default 16, width of the runtime bit-period divisor.
REQ-002 Parameter FIFO_DEPTH, default 4, TX FIFO entries; power of two, >= 2.
REQ-003 I_clk  input  1  sole clock; all logic on rising edge.
REQ-004 I_reset_n  input  1  synchronous, active-low reset.
REQ-005 I_div  input  DIV_W  bit period minus one, in clocks (0 -> 1 clock per bit).
REQ-006 I_cfg_bits  input  2  data bits per frame: 00=5, 01=6, 10=7, 11=8.
REQ-007 I_cfg_parity  input  2  parity: 00=none, 01=even, 10=odd, 11=none.
REQ-008 I_cfg_stop  input  1  stop bits: 0=one, 1=two.
REQ-009 I_data  input  8  byte to send; bits above the configured width are ignored.
REQ-010 I_valid  input  1  write request.
REQ-011 O_ready  output  1  FIFO not full; a write is accepted on any edge where I_valid and O_ready are both 1.
REQ-012 O_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 O_busy  output  1  high from frame load through the final stop-bit clock.
REQ-014 O_done  output  1  one-clock pulse on the last clock of each frame's final stop bit.
REQ-015 O_data  output  1  serial line, idle high.

Function
REQ-016 The FIFO SHALL be first-in first-out, registered, and hold FIFO_DEPTH entries with wrap-around read/write pointers.
REQ-017 A push when full SHALL be impossible (O_ready=0); I_valid while full SHALL be ignored and no data lost or overwritten.
REQ-018 A simultaneous push and pop SHALL leave O_count unchanged and preserve order, including when full (the pop frees the slot only on the following cycle, so O_ready stays 0 that cycle).
REQ-019 FSM states: IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: O_data=1, O_busy=0; if O_count>0, pop head, latch byte, I_div, I_cfg_bits, I_cfg_parity, I_cfg_stop, go START.
REQ-021 Config inputs SHALL be sampled only at pop; changes mid-frame SHALL NOT affect the current frame.
REQ-022 START: O_data=0 for exactly I_div+1 clocks, then DATA.
REQ-023 DATA: LSB first, each bit exactly I_div+1 clocks, 5..8 bits per latched config; then PARITY if parity enabled, else STOP.
REQ-024 PARITY: one bit period; even = XOR of sent data bits; odd = its inverse; only configured data bits included.
REQ-025 STOP: O_data=1 for (I_div+1) x (1 or 2) clocks; O_done pulses on the final clock; next state IDLE.
REQ-026 Back-to-back: if FIFO non-empty at frame end, the next start bit SHALL begin exactly one clock (IDLE pop cycle) after the last stop clock.
REQ-027 Latency: write to empty FIFO with FSM idle -> O_data falls 2 clocks after the accepting edge.
REQ-028 Bit-period counter SHALL be DIV_W bits, compare against latched divisor, never wrap within a bit.
REQ-029 O_data SHALL be registered; no combinational path from inputs to O_data.

Reset
REQ-030 On I_reset_n=0 at an edge: state=IDLE, FIFO flushed (O_count=0), O_ready=1, O_busy=0, O_done=0, O_data=1, counters cleared.
REQ-031 Reset mid-frame SHALL abort the frame; O_data=1 from the next clock; pending FIFO data discarded.
REQ-032 Writes presented during reset SHALL NOT be accepted.

Verification
REQ-033 I_div=3, 8N1, write 0xA5 -> O_data: 0 x4 clk, bits 1,0,1,0,0,1,0,1 x4 each, 1 x4, O_done pulse, 40 clocks total.
REQ-034 I_div=0, 7E2, write 0x41 -> start, 1,0,0,0,0,0,1, parity 0, stop 1,1; 11 clocks; upper bit ignored.
REQ-035 FIFO_DEPTH=4, I_div=9: write 6 bytes back-to-back -> first pops, next 4 accepted, O_ready=0 on 6th; all 5 sent in order with one idle clock between frames.
REQ-036 5O1 write 0x1F with I_cfg_bits changed to 11 mid-frame -> 5 data bits 1,1,1,1,1, parity 0, frame unaffected.
REQ-037 Reset asserted during DATA with 2 entries queued -> O_data=1 next clock, O_count=0, O_ready=1, no further frames.
REQ-038 Push and pop same cycle at O_count=4 -> O_count stays 4, O_ready=0, order preserved.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Host-side bundle for uart_tx_fifo: write handshake, frame config, status and serial line.
interface uart_tx_fifo_if #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
);
    logic [DIV_W-1:0]              I_div;
    logic [1:0]                    I_cfg_bits;
    logic [1:0]                    I_cfg_parity;
    logic                          I_cfg_stop;
    logic [7:0]                    I_data;
    logic                          I_valid;
    logic                          O_ready;
    logic [$clog2(FIFO_DEPTH):0]   O_count;
    logic                          O_busy;
    logic                          O_done;
    logic                          O_data;

    modport master (
        output I_div, I_cfg_bits, I_cfg_parity, I_cfg_stop, I_data, I_valid,
        input  O_ready, O_count, O_busy, O_done, O_data
    );

    modport slave (
        input  I_div, I_cfg_bits, I_cfg_parity, I_cfg_stop, I_data, I_valid,
        output O_ready, O_count, O_busy, O_done, O_data
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO; the line falls 2 clocks after a write into an empty, idle block.
// O_ready drops while the FIFO is full; a write presented then is not taken and must be held by the sender.
module uart_tx_fifo #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          I_clk,
    input  logic          I_reset_n,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, push, pop;

    state_t        state_q;
    logic [7:0]    byte_q;
    logic [DIV_W-1:0] div_q, cnt_q;
    logic [2:0]    last_bit_q, bit_idx_q;
    logic          par_en_q, par_bit_q, stop2_q, stop_idx_q;
    logic          data_q, busy_q, done_q;

    logic [7:0]    mask_dat, head_dat;
    logic          head_par_en, head_par_bit, bit_end;

    assign full = (count_q == CW'(FIFO_DEPTH));
    assign push = I_reset_n && bus.I_valid && !full;
    assign pop  = (state_q == IDLE) && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge I_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.I_data;
        end
    end

    // Bits above the configured width are cleared here so parity and shifting never see them.
    always_comb begin
        mask_dat     = 8'hFF >> (2'd3 - bus.I_cfg_bits);
        head_dat     = mem_q[rd_ptr_q] & mask_dat;
        head_par_en  = (bus.I_cfg_parity == 2'b01) || (bus.I_cfg_parity == 2'b10);
        head_par_bit = (^head_dat) ^ (bus.I_cfg_parity == 2'b10);
    end

    assign bit_end = (cnt_q == div_q);

    // Line level is registered from the state, so it trails the state register by one clock.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            state_q    <= IDLE;
            byte_q     <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            last_bit_q <= '0;
            bit_idx_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            data_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= bit_end ? '0 : cnt_q + DIV_W'(1);
            case (state_q)
                IDLE: begin
                    data_q <= 1'b1;
                    busy_q <= pop;
                    cnt_q  <= '0;
                    if (pop) begin
                        byte_q     <= head_dat;
                        div_q      <= bus.I_div;
                        last_bit_q <= 3'd4 + {1'b0, bus.I_cfg_bits};
                        par_en_q   <= head_par_en;
                        par_bit_q  <= head_par_bit;
                        stop2_q    <= bus.I_cfg_stop;
                        state_q    <= START;
                    end
                end
                START: begin
                    data_q <= 1'b0;
                    busy_q <= 1'b1;
                    if (bit_end) begin
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    data_q <= byte_q[bit_idx_q];
                    busy_q <= 1'b1;
                    if (bit_end) begin
                        if (bit_idx_q == last_bit_q) begin
                            stop_idx_q <= 1'b0;
                            state_q    <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    data_q <= par_bit_q;
                    busy_q <= 1'b1;
                    if (bit_end) begin
                        stop_idx_q <= 1'b0;
                        state_q    <= STOP;
                    end
                end
                STOP: begin
                    data_q <= 1'b1;
                    busy_q <= 1'b1;
                    if (bit_end) begin
                        if (stop_idx_q == stop2_q) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.O_ready = !full;
    assign bus.O_count = count_q;
    assign bus.O_busy  = busy_q;
    assign bus.O_done  = done_q;
    assign bus.O_data  = data_q;
endmodule
